spatz_vrf_wport_arbiter: RTL and testbench



---
 rtl/spatz_pkg.sv | 15 +
 rtl/spatz_rr_pick.sv | 30 +++
 rtl/spatz_vrf_wport_arbiter.sv | 171 +++++++++++++++++
 tb/tb_spatz_vrf_wport_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spatz_pkg.sv
// Shared Spatz types for the vector register file datapath.
// Widths here are the project defaults consumed by the VRF write-port arbiter.
package spatz_pkg;

  localparam int unsigned VrfAddrWidth = 8;
  localparam int unsigned VrfDataWidth = 32;
  localparam int unsigned VrfBeWidth   = VrfDataWidth / 8;
  localparam int unsigned SpatzIdWidth = 3;

  typedef logic [VrfAddrWidth-1:0] vrf_addr_t;
  typedef logic [VrfDataWidth-1:0] vrf_data_t;
  typedef logic [VrfBeWidth-1:0]   vrf_be_t;
  typedef logic [SpatzIdWidth-1:0] spatz_id_t;

endpackage

// File: rtl/spatz_rr_pick.sv
// Combinational round-robin picker: finds the first set request at or after
// start_i, wrapping around, and reports its index.
module spatz_rr_pick #(
  parameter  int unsigned N    = 2,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] start_i,
  output logic            valid_o,
  output logic [IdxW-1:0] idx_o
);

  int unsigned pos;

  always_comb begin
    // NOTE: every output and temporary gets a default first so no path
    // through this block can infer a latch.
    valid_o = 1'b0;
    idx_o   = '0;
    pos     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = (int'(start_i) + k) % N;
      if (!valid_o && req_i[pos]) begin
        valid_o = 1'b1;
        idx_o   = IdxW'(pos);
      end
    end
  end

endmodule

// File: rtl/spatz_vrf_wport_arbiter.sv
// Arbitrates the single VRF write port between the vector units into a
// one-entry output register: port 0 has priority, the rest share round-robin.
module spatz_vrf_wport_arbiter
  import spatz_pkg::*;
#(
  parameter int unsigned NrPorts = 3,
  parameter int unsigned MaxWait = 8
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic      [NrPorts-1:0]           req_we_i,
  input  vrf_addr_t [NrPorts-1:0]           req_waddr_i,
  input  vrf_data_t [NrPorts-1:0]           req_wdata_i,
  input  vrf_be_t   [NrPorts-1:0]           req_wbe_i,
  input  spatz_id_t [NrPorts-1:0]           req_id_i,
  output logic      [NrPorts-1:0]           req_wvalid_o,
  output vrf_addr_t                         vrf_waddr_o,
  output vrf_data_t                         vrf_wdata_o,
  output vrf_be_t                           vrf_wbe_o,
  output logic                              vrf_we_o,
  input  logic                              vrf_wvalid_i,
  output spatz_id_t                         vrf_id_o,
  output logic                              done_valid_o,
  output logic      [$clog2(NrPorts)-1:0]   done_port_o,
  output spatz_id_t                         done_id_o
);

  localparam int unsigned PortW  = $clog2(NrPorts);
  localparam int unsigned WaitW  = $clog2(MaxWait + 1);
  localparam int unsigned RrN    = NrPorts - 1;
  localparam int unsigned RrIdxW = (RrN > 1) ? $clog2(RrN) : 1;
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MaxWait);

  typedef struct packed {
    vrf_addr_t        waddr;
    vrf_data_t        wdata;
    vrf_be_t          wbe;
    spatz_id_t        id;
    logic [PortW-1:0] src;
  } wreg_t;

  typedef enum logic {
    WrEmpty = 1'b0,
    WrFull  = 1'b1
  } wstate_e;

  wstate_e          state_q, state_d;
  wreg_t            wreg_q, wreg_d;
  logic [PortW-1:0] rr_q, rr_d;
  logic [WaitW-1:0] wait_q [RrN];
  logic [WaitW-1:0] wait_d [RrN];

  logic              free;
  logic              done_valid;
  logic              grant_valid;
  logic [PortW-1:0]  grant_idx;
  logic              starve_hit;
  logic [PortW-1:0]  starve_idx;
  logic              rr_valid;
  logic [RrIdxW-1:0] rr_start;
  logic [RrIdxW-1:0] rr_idx;

  // Low-priority ports live at picker bit p-1; rr_q stays in 1..NrPorts-1.
  assign rr_start = RrIdxW'(rr_q - PortW'(1));

  spatz_rr_pick #(
    .N (RrN)
  ) i_rr_pick (
    .req_i   (req_we_i[NrPorts-1:1]),
    .start_i (rr_start),
    .valid_o (rr_valid),
    .idx_o   (rr_idx)
  );

  assign free = (state_q == WrEmpty) || vrf_wvalid_i;

  // NOTE: reset is synchronous, so the combinational handshakes are masked
  // while rst_ni is low; otherwise a grant or done pulse could fire in a
  // cycle whose capture is discarded by the reset.
  assign done_valid = rst_ni && (state_q == WrFull) && vrf_wvalid_i;

  always_comb begin
    starve_hit = 1'b0;
    starve_idx = '0;
    for (int p = int'(NrPorts) - 1; p >= 1; p--) begin
      if (req_we_i[p] && (wait_q[p-1] == WaitMax)) begin
        starve_hit = 1'b1;
        starve_idx = PortW'(p);
      end
    end

    grant_valid = 1'b0;
    grant_idx   = '0;
    if (rst_ni && free) begin
      if (starve_hit) begin
        grant_valid = 1'b1;
        grant_idx   = starve_idx;
      end else if (req_we_i[0]) begin
        grant_valid = 1'b1;
      end else if (rr_valid) begin
        grant_valid = 1'b1;
        grant_idx   = PortW'(rr_idx) + PortW'(1);
      end
    end
  end

  always_comb begin
    req_wvalid_o = '0;
    for (int unsigned p = 0; p < NrPorts; p++) begin
      req_wvalid_o[p] = grant_valid && (grant_idx == PortW'(p));
    end
  end

  always_comb begin
    state_d = state_q;
    wreg_d  = wreg_q;
    rr_d    = rr_q;

    if (grant_valid) begin
      state_d      = WrFull;
      wreg_d.waddr = req_waddr_i[grant_idx];
      wreg_d.wdata = req_wdata_i[grant_idx];
      wreg_d.wbe   = req_wbe_i[grant_idx];
      wreg_d.id    = req_id_i[grant_idx];
      wreg_d.src   = grant_idx;
      if (grant_idx != '0) begin
        rr_d = (grant_idx == PortW'(NrPorts - 1)) ? PortW'(1) : grant_idx + PortW'(1);
      end
    end else if (done_valid) begin
      state_d = WrEmpty;
    end

    for (int unsigned p = 0; p < RrN; p++) begin
      if (!req_we_i[p+1] || (grant_valid && (grant_idx == PortW'(p + 1)))) begin
        wait_d[p] = '0;
      end else if (wait_q[p] != WaitMax) begin
        wait_d[p] = wait_q[p] + WaitW'(1);
      end else begin
        wait_d[p] = wait_q[p];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= WrEmpty;
      wreg_q  <= '0;
      rr_q    <= PortW'(1);
      for (int unsigned p = 0; p < RrN; p++) begin
        wait_q[p] <= '0;
      end
    end else begin
      state_q <= state_d;
      wreg_q  <= wreg_d;
      rr_q    <= rr_d;
      for (int unsigned p = 0; p < RrN; p++) begin
        wait_q[p] <= wait_d[p];
      end
    end
  end

  assign vrf_we_o     = (state_q == WrFull);
  assign vrf_waddr_o  = wreg_q.waddr;
  assign vrf_wdata_o  = wreg_q.wdata;
  assign vrf_wbe_o    = wreg_q.wbe;
  assign vrf_id_o     = wreg_q.id;
  assign done_valid_o = done_valid;
  assign done_port_o  = done_valid ? wreg_q.src : '0;
  assign done_id_o    = done_valid ? wreg_q.id  : '0;

endmodule

// File: tb/tb_spatz_vrf_wport_arbiter.sv
// Randomized bench for the VRF write-port arbiter against a behavioural
// model of the grant rules, plus directed scenarios with fixed expectations.
module tb_spatz_vrf_wport_arbiter;
  import spatz_pkg::*;

  localparam int NP   = 3;
  localparam int MAXW = 3;

  logic                  clk;
  logic                  rst_n;
  logic      [NP-1:0]    req_we;
  vrf_addr_t [NP-1:0]    req_waddr;
  vrf_data_t [NP-1:0]    req_wdata;
  vrf_be_t   [NP-1:0]    req_wbe;
  spatz_id_t [NP-1:0]    req_id;
  logic      [NP-1:0]    req_wvalid;
  vrf_addr_t             vrf_waddr;
  vrf_data_t             vrf_wdata;
  vrf_be_t               vrf_wbe;
  logic                  vrf_we;
  logic                  vrf_wvalid;
  spatz_id_t             vrf_id;
  logic                  done_valid;
  logic      [1:0]       done_port;
  spatz_id_t             done_id;

  spatz_vrf_wport_arbiter #(
    .NrPorts (NP),
    .MaxWait (MAXW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_we_i     (req_we),
    .req_waddr_i  (req_waddr),
    .req_wdata_i  (req_wdata),
    .req_wbe_i    (req_wbe),
    .req_id_i     (req_id),
    .req_wvalid_o (req_wvalid),
    .vrf_waddr_o  (vrf_waddr),
    .vrf_wdata_o  (vrf_wdata),
    .vrf_wbe_o    (vrf_wbe),
    .vrf_we_o     (vrf_we),
    .vrf_wvalid_i (vrf_wvalid),
    .vrf_id_o     (vrf_id),
    .done_valid_o (done_valid),
    .done_port_o  (done_port),
    .done_id_o    (done_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Requesters
  bit        active [NP];
  int        want   [NP];
  int        force_addr [NP];
  vrf_addr_t p_addr [NP];
  vrf_data_t p_data [NP];
  vrf_be_t   p_be   [NP];
  spatz_id_t p_id   [NP];

  // Reference model of the arbiter, written from the grant rules
  int        m_full, m_src, m_rr, m_last_grant;
  int        m_wait [NP];
  vrf_addr_t m_addr;
  vrf_data_t m_data;
  vrf_be_t   m_be;
  spatz_id_t m_id;

  // Observations of the most recent cycle for directed checks
  logic [NP-1:0] obs_ack;
  logic          obs_done, obs_we;
  logic [1:0]    obs_dport;
  vrf_addr_t     obs_addr;
  logic [63:0]   obs_wait1, obs_rr;

  task automatic model_reset();
    m_full = 0; m_src = 0; m_rr = 1; m_last_grant = -1;
    m_addr = '0; m_data = '0; m_be = '0; m_id = '0;
    for (int p = 0; p < NP; p++) m_wait[p] = 0;
  endtask

  task automatic cycle(input logic vwv, input logic rst_v);
    int g;
    bit free, done;
    @(negedge clk);
    for (int p = 0; p < NP; p++) begin
      if (active[p] && m_last_grant == p) active[p] = 0;
      if (!active[p] && want[p] > 0) begin
        active[p] = 1;
        want[p]--;
        p_addr[p] = vrf_addr_t'($urandom);
        p_data[p] = vrf_data_t'($urandom);
        p_be[p]   = vrf_be_t'($urandom);
        p_id[p]   = spatz_id_t'($urandom);
        if (force_addr[p] >= 0) begin
          p_addr[p] = vrf_addr_t'(force_addr[p]);
          force_addr[p] = -1;
        end
      end
      req_we[p]    = active[p];
      req_waddr[p] = p_addr[p];
      req_wdata[p] = p_data[p];
      req_wbe[p]   = p_be[p];
      req_id[p]    = p_id[p];
    end
    vrf_wvalid = vwv;
    rst_n      = rst_v;
    #1;
    obs_ack   = req_wvalid;
    obs_done  = done_valid;
    obs_dport = done_port;
    obs_we    = vrf_we;
    obs_addr  = vrf_waddr;
    obs_wait1 = 64'(dut.wait_q[0]);
    obs_rr    = 64'(dut.rr_q);
    if (!rst_v) begin
      check("rst_ack", 64'(req_wvalid), 64'(0));
      check("rst_done", 64'(done_valid), 64'(0));
      model_reset();
    end else begin
      free = (m_full == 0) || vwv;
      done = (m_full != 0) && vwv;
      g = -1;
      if (free) begin
        for (int p = 1; p < NP; p++)
          if (g < 0 && req_we[p] && m_wait[p] == MAXW) g = p;
        if (g < 0 && req_we[0]) g = 0;
        for (int k = 0; k < NP - 1; k++) begin
          int p;
          p = 1 + (m_rr - 1 + k) % (NP - 1);
          if (g < 0 && req_we[p]) g = p;
        end
      end
      check("ack", 64'(req_wvalid), (g >= 0) ? 64'(1) << g : 64'(0));
      check("vrf_we", 64'(vrf_we), 64'(m_full));
      check("vrf_waddr", 64'(vrf_waddr), 64'(m_addr));
      check("vrf_wdata", 64'(vrf_wdata), 64'(m_data));
      check("vrf_wbe", 64'(vrf_wbe), 64'(m_be));
      check("vrf_id", 64'(vrf_id), 64'(m_id));
      check("done_valid", 64'(done_valid), 64'(done));
      check("done_port", 64'(done_port), done ? 64'(m_src) : 64'(0));
      check("done_id", 64'(done_id), done ? 64'(m_id) : 64'(0));
      check("rr", obs_rr, 64'(m_rr));
      check("wait1", obs_wait1, 64'(m_wait[1]));
      check("wait2", 64'(dut.wait_q[1]), 64'(m_wait[2]));
      if (g >= 0) begin
        m_full = 1; m_src = g;
        m_addr = p_addr[g]; m_data = p_data[g]; m_be = p_be[g]; m_id = p_id[g];
        if (g >= 1) m_rr = (g == NP - 1) ? 1 : g + 1;
      end else if (done) begin
        m_full = 0;
      end
      for (int p = 1; p < NP; p++) begin
        if (!req_we[p] || g == p) m_wait[p] = 0;
        else if (m_wait[p] < MAXW) m_wait[p]++;
      end
      m_last_grant = g;
    end
  endtask

  task automatic do_reset();
    for (int p = 0; p < NP; p++) begin
      active[p] = 0; want[p] = 0; force_addr[p] = -1;
    end
    cycle(1'b1, 1'b0);
  endtask

  // Requesters must hold req_we until acknowledged.
  logic [NP-1:0] prev_req, prev_ack;
  logic          prev_ok = 1'b0;
  always @(posedge clk) begin
    if (rst_n && prev_ok) begin
      for (int p = 0; p < NP; p++)
        assert (!(prev_req[p] && !prev_ack[p] && !req_we[p]))
          else $error("port %0d dropped its request before the ack", p);
    end
    prev_req <= req_we;
    prev_ack <= req_wvalid;
    prev_ok  <= rst_n;
  end

  vrf_addr_t bp_addr;
  logic [NP-1:0] exp_ack;

  initial begin
    rst_n = 1'b0; vrf_wvalid = 1'b0;
    req_we = '0; req_waddr = '0; req_wdata = '0; req_wbe = '0; req_id = '0;
    model_reset();
    for (int p = 0; p < NP; p++) begin
      active[p] = 0; want[p] = 0; force_addr[p] = -1;
      p_addr[p] = '0; p_data[p] = '0; p_be[p] = '0; p_id[p] = '0;
    end
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);

    // Reset state
    cycle(1'b0, 1'b1);
    check("reset_we", 64'(obs_we), 64'(0));
    check("reset_addr", 64'(obs_addr), 64'(0));
    check("reset_rr", obs_rr, 64'(1));

    // Single port
    do_reset();
    force_addr[2] = 'h10; want[2] = 1;
    cycle(1'b1, 1'b1);
    check("sp_ack", 64'(obs_ack), 64'(3'b100));
    cycle(1'b1, 1'b1);
    check("sp_we", 64'(obs_we), 64'(1));
    check("sp_addr", 64'(obs_addr), 64'('h10));
    check("sp_done", 64'(obs_done), 64'(1));
    check("sp_dport", 64'(obs_dport), 64'(2));
    cycle(1'b1, 1'b1);
    check("sp_done_once", 64'(obs_done), 64'(0));

    // Round-robin between ports 1 and 2
    do_reset();
    want[1] = 100; want[2] = 100;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'b1);
      exp_ack = (i % 2 == 0) ? 3'b010 : 3'b100;
      check("rr_seq", 64'(obs_ack), 64'(exp_ack));
    end

    // Priority and starvation
    do_reset();
    want[0] = 100; want[1] = 100;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1);
      exp_ack = (i == 3) ? 3'b010 : 3'b001;
      check("starve_seq", 64'(obs_ack), 64'(exp_ack));
      if (i == 3) check("starve_wait_max", obs_wait1, 64'(MAXW));
      if (i == 4) check("starve_wait_clr", obs_wait1, 64'(0));
    end

    // Backpressure
    do_reset();
    want[0] = 1; want[1] = 1; want[2] = 1;
    cycle(1'b1, 1'b1);
    check("bp_first_ack", 64'(obs_ack), 64'(3'b001));
    bp_addr = p_addr[0];
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1);
      check("bp_stall_ack", 64'(obs_ack), 64'(0));
      check("bp_stall_done", 64'(obs_done), 64'(0));
      check("bp_hold_addr", 64'(obs_addr), 64'(bp_addr));
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1);
      check("bp_drain_done", 64'(obs_done), 64'(1));
      check("bp_drain_port", 64'(obs_dport), 64'(i));
    end

    // Reset mid-operation
    do_reset();
    want[1] = 1;
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    check("mid_full", 64'(obs_we), 64'(1));
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    check("mid_we", 64'(obs_we), 64'(0));
    check("mid_addr", 64'(obs_addr), 64'(0));
    check("mid_rr", obs_rr, 64'(1));
    check("mid_done", 64'(obs_done), 64'(0));

    // Spurious ack while empty
    do_reset();
    cycle(1'b1, 1'b1);
    check("spur_done", 64'(obs_done), 64'(0));
    check("spur_we", 64'(obs_we), 64'(0));
    cycle(1'b0, 1'b1);
    check("spur_we_after", 64'(obs_we), 64'(0));

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int p = 0; p < NP; p++)
        if (!active[p] && want[p] == 0 && $urandom_range(0, 3) == 0)
          want[p] = $urandom_range(1, 4);
      if ($urandom_range(0, 299) == 0) cycle(1'b1, 1'b0);
      else cycle($urandom_range(0, 9) < 7, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
